// File: rtl/pixel_writer.sv
// Pixel writer: deserializes rasterizer pixel words, clips them, queues them and writes them to framebuffer memory.
// Optional build macro ALPHA_TEST_EN: drop pixels whose colour alpha bit (bit0) is clear.
module pixel_writer #(
  parameter int unsigned FRAC   = 6,
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 240,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              PIX_VALID,
  input  logic              PX,
  input  logic              PY,
  input  logic              PC,
  input  logic              TRI_DONE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [15:0]       MEM_DATA,
  output logic              MEM_WE,
  input  logic              MEM_READY,
  output logic              TRI_DRAINED,
  output logic              OVERFLOW,
  output logic [15:0]       DROP_CNT,
  output logic [15:0]       CLIP_CNT,
  output logic              BUSY
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  logic        state;
  logic [3:0]  bit_cnt;
  logic [14:0] sr_x, sr_y, sr_c;
  logic [15:0] word_x, word_y, word_c;
  logic signed [15:0] ix, iy;
  logic        last, clip, alpha_ok, pix_ok, push, pop, full;
  logic [ADDR_W-1:0] push_addr;

  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [15:0]       fifo_data [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [PW:0]       count;
  logic              done_pend;

  // The final bit is taken straight from the pins so the word is complete on the 16th edge.
  assign word_x = {sr_x, PX};
  assign word_y = {sr_y, PY};
  assign word_c = {sr_c, PC};

  assign last = (state == ST_SHIFT) && (bit_cnt == 4'd15);

  always_comb begin
    ix = $signed(word_x) >>> FRAC;
    iy = $signed(word_y) >>> FRAC;
    clip = ix[15] || iy[15] ||
           ({16'd0, ix} >= WIDTH) || ({16'd0, iy} >= HEIGHT);
    push_addr = ADDR_W'({16'd0, iy} * WIDTH + {16'd0, ix});
  end

`ifdef ALPHA_TEST_EN
  assign alpha_ok = word_c[0];
`else
  assign alpha_ok = 1'b1;
`endif

  assign full   = (count == DEPTH_C);
  assign MEM_WE = (count != '0);
  assign pop    = MEM_WE && MEM_READY;
  assign pix_ok = last && !clip && alpha_ok;
  assign push   = pix_ok && (!full || pop);

  assign MEM_ADDR    = MEM_WE ? fifo_addr[rd_ptr] : '0;
  assign MEM_DATA    = MEM_WE ? fifo_data[rd_ptr] : '0;
  assign TRI_DRAINED = done_pend && (state == ST_IDLE) && (count == '0);
  assign BUSY        = (state == ST_SHIFT) || (count != '0) || done_pend;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      sr_x    <= '0;
      sr_y    <= '0;
      sr_c    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          if (PIX_VALID) state <= ST_SHIFT;
        end
        default: begin
          sr_x    <= word_x[14:0];
          sr_y    <= word_y[14:0];
          sr_c    <= word_c[14:0];
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_addr[wr_ptr] <= push_addr;
      fifo_data[wr_ptr] <= word_c;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OVERFLOW  <= 1'b0;
      DROP_CNT  <= '0;
      CLIP_CNT  <= '0;
      done_pend <= 1'b0;
    end else begin
      if (pix_ok && !push) begin
        OVERFLOW <= 1'b1;
        if (DROP_CNT != '1) DROP_CNT <= DROP_CNT + 16'd1;
      end
      if (last && clip && CLIP_CNT != '1) CLIP_CNT <= CLIP_CNT + 16'd1;
      // A new TRI_DONE wins over the clear so a back-to-back triangle is not lost.
      if (TRI_DONE)         done_pend <= 1'b1;
      else if (TRI_DRAINED) done_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_writer.sv
// Scoreboard bench for pixel_writer: directed cases plus randomized pixels against a behavioural model.
module tb_pixel_writer;

  logic        CLK = 1'b0, RST_N = 1'b0, PIX_VALID = 1'b0;
  logic        PX = 1'b0, PY = 1'b0, PC = 1'b0, TRI_DONE = 1'b0, MEM_READY = 1'b0;
  logic [16:0] MEM_ADDR;
  logic [15:0] MEM_DATA, DROP_CNT, CLIP_CNT;
  logic        MEM_WE, TRI_DRAINED, OVERFLOW, BUSY;

  pixel_writer #(.FRAC(6), .WIDTH(320), .HEIGHT(240), .ADDR_W(17), .DEPTH(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .PIX_VALID(PIX_VALID), .PX(PX), .PY(PY), .PC(PC),
    .TRI_DONE(TRI_DONE), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_WE(MEM_WE),
    .MEM_READY(MEM_READY), .TRI_DRAINED(TRI_DRAINED), .OVERFLOW(OVERFLOW),
    .DROP_CNT(DROP_CNT), .CLIP_CNT(CLIP_CNT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];
  int  checks = 0, failures = 0;
  int  exp_clip = 0, exp_drop = 0, drain_seen = 0, ready_mode = 0;
  bit  exp_ovf = 0, exp_pend = 0, tb_shift = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: floor-divide coords by 64, clip to 320x240, queue up to 4 outstanding writes.
  task automatic model_push(input logic [15:0] px, input logic [15:0] py, input logic [15:0] pc);
    int x, y;
    x = int'($signed(px)) >>> 6;
    y = int'($signed(py)) >>> 6;
    if (x < 0 || x >= 320 || y < 0 || y >= 240) begin
      if (exp_clip < 65535) exp_clip++;
      return;
    end
`ifdef ALPHA_TEST_EN
    if (!pc[0]) return;
`endif
    if (exp_q.size() < 4) exp_q.push_back('{addr: (y * 320 + x) % 131072, data: int'(pc)});
    else begin
      exp_ovf = 1;
      if (exp_drop < 65535) exp_drop++;
    end
  endtask

  // MEM_READY changes just after the edge, after all other stimulus.
  initial forever begin
    @(posedge CLK); #2;
    case (ready_mode)
      0: MEM_READY = 1'b0;
      1: MEM_READY = 1'b1;
      default: MEM_READY = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: mid-cycle, the queue describes the state after the previous edge.
  initial forever begin
    bit exp_dr;
    wr_t e;
    @(negedge CLK);
    if (RST_N) begin
      exp_dr = exp_pend && exp_q.size() == 0 && !tb_shift;
      chk("busy", BUSY, longint'(tb_shift || exp_q.size() != 0 || exp_pend));
      chk("mem_we", MEM_WE, longint'(exp_q.size() != 0));
      if (TRI_DRAINED || exp_dr) chk("tri_drained", TRI_DRAINED, longint'(exp_dr));
      if (TRI_DRAINED) drain_seen++;
      if (exp_dr) exp_pend = 0;
      if (MEM_WE && MEM_READY && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", MEM_ADDR, e.addr);
        chk("wr_data", MEM_DATA, e.data);
      end
    end
  end

  task automatic send_pixel(input logic [15:0] px, input logic [15:0] py, input logic [15:0] pc,
                            input int done_at = -1, input int spur = -1);
    PIX_VALID = 1'b1;
    @(posedge CLK); #1;
    PIX_VALID = 1'b0;
    tb_shift = 1;
    for (int i = 15; i >= 0; i--) begin
      PX = px[i]; PY = py[i]; PC = pc[i];
      TRI_DONE  = (i == done_at);
      PIX_VALID = (i == spur);
      if (i == 0) begin
        @(negedge CLK); #1;
        model_push(px, py, pc);
      end
      @(posedge CLK); #1;
      PIX_VALID = 1'b0;
      if (TRI_DONE) begin
        TRI_DONE = 1'b0;
        exp_pend = 1;
      end
    end
    tb_shift = 0;
    PX = 1'b0; PY = 1'b0; PC = 1'b0;
  endtask

  task automatic tri_done();
    TRI_DONE = 1'b1;
    @(posedge CLK); #1;
    TRI_DONE = 1'b0;
    exp_pend = 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && (exp_q.size() != 0 || exp_pend); i++) idle(1);
    chk("drain_timeout", longint'(exp_q.size() != 0 || exp_pend), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mem_we"}, MEM_WE, 0);
    chk({tag, "_mem_addr"}, MEM_ADDR, 0);
    chk({tag, "_mem_data"}, MEM_DATA, 0);
    chk({tag, "_drained"}, TRI_DRAINED, 0);
    chk({tag, "_overflow"}, OVERFLOW, 0);
    chk({tag, "_drop"}, DROP_CNT, 0);
    chk({tag, "_clip"}, CLIP_CNT, 0);
    chk({tag, "_busy"}, BUSY, 0);
  endtask

  function automatic logic [15:0] rnd_coord(input int lo, input int hi);
    int v;
    v = lo + int'($urandom_range(0, hi - lo));
    return 16'((v <<< 6) | int'($urandom_range(0, 63)));
  endfunction

  initial begin
    int d0;
    idle(3);
    check_zero("reset");
    RST_N = 1'b1;

    // Basic write: x=10, y=20
    ready_mode = 1; idle(2);
    send_pixel(16'h0280, 16'h0500, 16'hF801);
    chk("t1_we", MEM_WE, 1);
    chk("t1_addr", MEM_ADDR, 6410);
    chk("t1_data", MEM_DATA, 16'hF801);
    idle(3);

    // Clipping on both x edges
    send_pixel(16'hFFC0, 16'h0040, 16'h1234);
    idle(1);
    chk("t2_clip1", CLIP_CNT, 1);
    send_pixel(16'h5000, 16'h0040, 16'h1235);
    idle(1);
    chk("t2_clip2", CLIP_CNT, 2);
    chk("t2_we", MEM_WE, 0);

    // Overflow with memory stalled
    ready_mode = 0; idle(2);
    for (int i = 0; i < 5; i++)
      send_pixel(16'((i + 1) << 6), 16'h0080, 16'(16'hA000 + i));
    idle(1);
    chk("t3_overflow", OVERFLOW, 1);
    chk("t3_drop", DROP_CNT, 1);
    chk("t3_head", MEM_ADDR, 2 * 320 + 1);
    ready_mode = 1;
    wait_drain(100);

    // Triangle drain
    d0 = drain_seen;
    send_pixel(16'h0100, 16'h0100, 16'h0F0F);
    send_pixel(16'h0140, 16'h0100, 16'h0F10);
    tri_done();
    wait_drain(100);
    idle(2);
    chk("t4_drain_after_writes", drain_seen - d0, 1);
    tri_done();
    idle(2);
    chk("t4_drain_idle", drain_seen - d0, 2);
    send_pixel(16'h0200, 16'h0200, 16'h7777, 5);
    wait_drain(100);
    idle(2);
    chk("t4_drain_mid_shift", drain_seen - d0, 3);

    // Reset during shift with a stalled write pending
    ready_mode = 0; idle(2);
    send_pixel(16'h0400, 16'h0400, 16'h5555);
    PIX_VALID = 1'b1;
    @(posedge CLK); #1;
    PIX_VALID = 1'b0;
    tb_shift = 1;
    for (int i = 15; i >= 8; i--) begin
      PX = 1'b1; PY = 1'b0; PC = 1'b1;
      @(posedge CLK); #1;
    end
    RST_N = 1'b0;
    tb_shift = 0; exp_q.delete(); exp_clip = 0; exp_drop = 0; exp_ovf = 0; exp_pend = 0;
    PX = 1'b0; PY = 1'b0; PC = 1'b0;
    #1;
    check_zero("midrst");
    @(posedge CLK); #1;
    RST_N = 1'b1;
    ready_mode = 1; idle(2);
    send_pixel(16'h0040, 16'h0040, 16'h4321);
    chk("t5_addr", MEM_ADDR, 321);
    wait_drain(50);

    // Alpha bit clear
    send_pixel(16'h0040, 16'h0040, 16'hFFFE);
`ifdef ALPHA_TEST_EN
    chk("t6_we", MEM_WE, 0);
`else
    chk("t6_we", MEM_WE, 1);
    chk("t6_data", MEM_DATA, 16'hFFFE);
`endif
    wait_drain(50);

    // Randomized traffic with random back-pressure
    ready_mode = 2;
    for (int n = 0; n < 80; n++) begin
      send_pixel(rnd_coord(-4, 335), rnd_coord(-4, 250), 16'($urandom),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1);
      case ($urandom_range(0, 5))
        0: idle(int'($urandom_range(1, 20)));
        1: tri_done();
        default: ;
      endcase
    end
    ready_mode = 1;
    wait_drain(200);
    idle(3);
    chk("rnd_clip", CLIP_CNT, exp_clip);
    chk("rnd_drop", DROP_CNT, exp_drop);
    chk("rnd_overflow", OVERFLOW, longint'(exp_ovf));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
